detect_centroid: RTL and testbench

DETECT_CENTROID -- requirements
Module: detect_centroid

---
 rtl/detect_centroid_if.sv | 25 ++
 rtl/detect_centroid.sv | 243 ++++++++++++++++++++++++
 tb/tb_detect_centroid.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/detect_centroid_if.sv
// detect_centroid_if: pixel stream into the centroid detector and the
// per-frame detection result back out.
//   master : camera / capture side (drives vsync and the pixel strobe)
//   slave  : detect_centroid
interface detect_centroid_if;
  logic        vsync;
  logic        pixel_valid;
  logic [7:0]  pixel;
  logic [9:0]  x_detect;
  logic [8:0]  y_detect;
  logic [19:0] detect_pos_pixel;
  logic        found;
  logic        detect_valid;
  logic        busy;

  modport master (
    output vsync, pixel_valid, pixel,
    input  x_detect, y_detect, detect_pos_pixel, found, detect_valid, busy
  );

  modport slave (
    input  vsync, pixel_valid, pixel,
    output x_detect, y_detect, detect_pos_pixel, found, detect_valid, busy
  );
endinterface

// File: rtl/detect_centroid.sv
// detect_centroid: accumulates the column/row sums of all lit pixels in a
// camera frame and, at each frame end, divides them by the lit-pixel count
// to report the centroid of the bright region.
//
// Frame end is the registered rising edge of vsync. Sums are snapshotted
// into two parallel restoring dividers (one quotient bit per cycle) while
// the accumulators clear and start collecting the next frame.
//
// Optional feature: define DETECT_SMOOTH_EN to average each new found
// centroid with the previous one ((old + new) >> 1).
module detect_centroid #(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int THRESH    = 200,
  parameter int MIN_COUNT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  detect_centroid_if.slave bus
);

  localparam int SUM_W     = 28;
  localparam int CNT_W     = 19;
  localparam int COL_W     = 10;
  localparam int ROW_W     = 9;
  localparam int ROW_CNT_W = 10;  // must be able to hold V_RES itself
  localparam int POS_W     = 20;
  localparam int STEP_W    = 5;

  localparam logic [COL_W-1:0]     COL_LAST  = COL_W'(H_RES - 1);
  localparam logic [ROW_CNT_W-1:0] ROW_LIM   = ROW_CNT_W'(V_RES);
  localparam logic [7:0]           THR       = 8'(THRESH);
  localparam logic [CNT_W-1:0]     MIN_CNT   = CNT_W'(MIN_COUNT);
  localparam logic [POS_W-1:0]     H_RES_P   = POS_W'(H_RES);
  localparam logic [STEP_W-1:0]    LAST_STEP = STEP_W'(SUM_W - 1);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  // One restoring divider: partial remainder plus the dividend register
  // that shifts left and collects quotient bits at its LSB.
  typedef struct packed {
    logic [CNT_W-1:0] rem;
    logic [SUM_W-1:0] dvd;
  } div_t;

  function automatic div_t div_step(input div_t cur, input logic [CNT_W-1:0] d);
    logic [CNT_W:0] trial;
    div_t           nxt;
    trial   = {cur.rem, cur.dvd[SUM_W-1]};
    nxt.dvd = {cur.dvd[SUM_W-2:0], 1'b0};
    if (trial >= {1'b0, d}) begin
      trial      = trial - {1'b0, d};
      nxt.dvd[0] = 1'b1;
    end
    // Remainder is always below the divisor, so it fits CNT_W bits.
    nxt.rem = trial[CNT_W-1:0];
    return nxt;
  endfunction

  // vsync edge detection and frame bookkeeping
  logic vsync_q, vsync_qq;
  logic frame_end, vsync_fall;
  logic clear_q;   // one cycle after a frame end: wipe accumulators
  logic armed_q;   // a frame start has been seen since reset

  // pixel position and accumulators
  logic [COL_W-1:0]     col_q, col_d, col_base;
  logic [ROW_CNT_W-1:0] row_q, row_d, row_base;
  logic [SUM_W-1:0]     sum_x_q, sum_x_d, sum_y_q, sum_y_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 accept, lit;

  // control and division
  state_t               state_q, state_d;
  logic                 snap;
  logic                 snap_found_q;
  logic [CNT_W-1:0]     divisor_q;
  div_t                 div_x_q, div_y_q;
  logic [STEP_W-1:0]    step_q;

  // results
  logic [COL_W-1:0]     x_q, x_new;
  logic [ROW_W-1:0]     y_q, y_new;
  logic [POS_W-1:0]     pos_q, pos_new;
  logic                 found_q, detect_valid_q;
`ifdef DETECT_SMOOTH_EN
  logic                 have_prev_q;
`endif

  assign frame_end  = vsync_q && !vsync_qq;
  assign vsync_fall = !vsync_q && vsync_qq;
  assign snap       = frame_end && armed_q && (state_q == IDLE);

  // Register vsync for edge detection; arm on the first frame start.
  // NOTE: flops use non-blocking (<=) so every register samples the
  // pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q  <= 1'b0;
      vsync_qq <= 1'b0;
      clear_q  <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      vsync_q  <= bus.vsync;
      vsync_qq <= vsync_q;
      clear_q  <= frame_end;
      if (vsync_fall) armed_q <= 1'b1;
    end
  end

  // Next position and accumulator values for the incoming pixel.
  // NOTE: every signal driven here gets a default at the top, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    col_base = (vsync_fall || clear_q) ? '0 : col_q;
    row_base = (vsync_fall || clear_q) ? '0 : row_q;
    sum_x_d  = clear_q ? '0 : sum_x_q;
    sum_y_d  = clear_q ? '0 : sum_y_q;
    count_d  = clear_q ? '0 : count_q;
    col_d    = col_base;
    row_d    = row_base;

    // Pixels during blanking or below the active area are dropped and do
    // not move the position counters.
    accept = bus.pixel_valid && !bus.vsync && (row_base < ROW_LIM);
    lit    = accept && (bus.pixel >= THR);

    if (accept) begin
      if (col_base == COL_LAST) begin
        col_d = '0;
        row_d = row_base + ROW_CNT_W'(1);
      end else begin
        col_d = col_base + COL_W'(1);
      end
    end

    if (lit) begin
      sum_x_d = sum_x_d + SUM_W'(col_base);
      sum_y_d = sum_y_d + SUM_W'(row_base);
      count_d = count_d + CNT_W'(1);
    end
  end

  // Position counters and accumulators.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q   <= '0;
      row_q   <= '0;
      sum_x_q <= '0;
      sum_y_q <= '0;
      count_q <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      sum_x_q <= sum_x_d;
      sum_y_q <= sum_y_d;
      count_q <= count_d;
    end
  end

  // Control FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Control FSM next state: divide only when enough pixels were lit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (snap) state_d = (count_q >= MIN_CNT) ? DIV : DONE;
      DIV:     if (step_q == LAST_STEP) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // New coordinates from the quotients, optionally averaged with the
  // previous result.
  always_comb begin
    x_new = div_x_q.dvd[COL_W-1:0];
    y_new = div_y_q.dvd[ROW_W-1:0];
`ifdef DETECT_SMOOTH_EN
    if (have_prev_q) begin
      x_new = COL_W'(({1'b0, x_q} + {1'b0, div_x_q.dvd[COL_W-1:0]}) >> 1);
      y_new = ROW_W'(({1'b0, y_q} + {1'b0, div_y_q.dvd[ROW_W-1:0]}) >> 1);
    end
`endif
    pos_new = POS_W'(y_new) * H_RES_P + POS_W'(x_new);
  end

  // Snapshot, divider iteration and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_x_q        <= '0;
      div_y_q        <= '0;
      divisor_q      <= '0;
      step_q         <= '0;
      snap_found_q   <= 1'b0;
      x_q            <= '0;
      y_q            <= '0;
      pos_q          <= '0;
      found_q        <= 1'b0;
      detect_valid_q <= 1'b0;
`ifdef DETECT_SMOOTH_EN
      have_prev_q    <= 1'b0;
`endif
    end else begin
      if (snap) begin
        div_x_q      <= '{rem: '0, dvd: sum_x_q};
        div_y_q      <= '{rem: '0, dvd: sum_y_q};
        divisor_q    <= count_q;
        step_q       <= '0;
        snap_found_q <= (count_q >= MIN_CNT);
      end else if (state_q == DIV) begin
        div_x_q <= div_step(div_x_q, divisor_q);
        div_y_q <= div_step(div_y_q, divisor_q);
        step_q  <= step_q + STEP_W'(1);
      end

      detect_valid_q <= (state_q == DONE);
      if (state_q == DONE) begin
        found_q <= snap_found_q;
        if (snap_found_q) begin
          x_q   <= x_new;
          y_q   <= y_new;
          pos_q <= pos_new;
`ifdef DETECT_SMOOTH_EN
          have_prev_q <= 1'b1;
`endif
        end
      end
    end
  end

  assign bus.x_detect         = x_q;
  assign bus.y_detect         = y_q;
  assign bus.detect_pos_pixel = pos_q;
  assign bus.found            = found_q;
  assign bus.detect_valid     = detect_valid_q;
  assign bus.busy             = (state_q == DIV);

endmodule

// File: tb/tb_detect_centroid.sv
// tb_detect_centroid: streams frames into detect_centroid and compares each
// result against a centroid computed directly from the frame image.
module tb_detect_centroid;

  localparam int H_RES     = 640;
  localparam int V_RES     = 480;
  localparam int THRESH    = 200;
  localparam int MIN_COUNT = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  detect_centroid_if bus ();

  detect_centroid #(
    .H_RES    (H_RES),
    .V_RES    (V_RES),
    .THRESH   (THRESH),
    .MIN_COUNT(MIN_COUNT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Frame image, row-major, pixel i sits at column i%H_RES, row i/H_RES.
  logic [7:0] img[$];

  // Expected result registers of the reference model.
  int   exp_x, exp_y, exp_pos;
  logic exp_found;
  bit   exp_have;

  task automatic model_clear();
    exp_x = 0; exp_y = 0; exp_pos = 0; exp_found = 1'b0; exp_have = 1'b0;
  endtask

  task automatic fill(input int rows, input logic [7:0] bg);
    img.delete();
    for (int i = 0; i < rows * H_RES; i++) img.push_back(bg);
  endtask

  task automatic put_block(input int c0, input int c1, input int r0, input int r1,
                           input logic [7:0] v);
    for (int r = r0; r <= r1; r++)
      for (int c = c0; c <= c1; c++) img[r * H_RES + c] = v;
  endtask

  // Centroid of the current image; returns the expected latency.
  task automatic model_frame(output int lat);
    longint sx = 0, sy = 0, n = 0;
    int     nx, ny;
    foreach (img[i]) begin
      if (img[i] >= THRESH) begin
        sx += i % H_RES;
        sy += i / H_RES;
        n++;
      end
    end
    if (n >= MIN_COUNT) begin
      nx = int'(sx / n);
      ny = int'(sy / n);
`ifdef DETECT_SMOOTH_EN
      if (exp_have) begin
        nx = (exp_x + nx) / 2;
        ny = (exp_y + ny) / 2;
      end
`endif
      exp_x = nx; exp_y = ny; exp_pos = ny * H_RES + nx;
      exp_found = 1'b1; exp_have = 1'b1;
      lat = 30;
    end else begin
      exp_found = 1'b0;
      lat = 2;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0; bus.vsync = 1'b1; bus.pixel_valid = 1'b0; bus.pixel = 8'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_clear();
  endtask

  // Leave blanking, stream the image one pixel per cycle, then go idle.
  task automatic stream_frame();
    @(negedge clk);
    bus.vsync = 1'b0;
    repeat (3) @(negedge clk);
    foreach (img[i]) begin
      bus.pixel_valid = 1'b1;
      bus.pixel       = img[i];
      @(negedge clk);
    end
    bus.pixel_valid = 1'b0;
    bus.pixel       = 8'd0;
    @(negedge clk);
  endtask

  // Raise vsync and check the single result pulse against the model.
  task automatic end_frame_and_check(input string name, input int lat);
    int         pulses = 0, seen = -1;
    logic [9:0] ox = 'x;
    logic [8:0] oy = 'x;
    logic [19:0] opos = 'x;
    logic       ofound = 1'bx;
    @(negedge clk);
    bus.vsync = 1'b1;
    @(posedge clk);  // cycle in which the rise is registered
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        checks++;
        if (bus.busy !== (lat == 30)) begin
          errors++;
          $display("FAIL %s busy_start: got %b want %b", name, bus.busy, (lat == 30));
        end
      end
      if (k == 29) begin
        checks++;
        if (bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL %s busy_end: got %b want 0", name, bus.busy);
        end
      end
      if (bus.detect_valid === 1'b1) begin
        pulses++;
        if (seen < 0) begin
          seen = k; ox = bus.x_detect; oy = bus.y_detect;
          opos = bus.detect_pos_pixel; ofound = bus.found;
        end
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL %s pulses: got %0d want 1", name, pulses); end
    checks++;
    if (seen != lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, seen, lat); end
    checks++;
    if (ofound !== exp_found) begin errors++; $display("FAIL %s found: got %b want %b", name, ofound, exp_found); end
    checks++;
    if (ox !== 10'(exp_x)) begin errors++; $display("FAIL %s x_detect: got %0d want %0d", name, ox, exp_x); end
    checks++;
    if (oy !== 9'(exp_y)) begin errors++; $display("FAIL %s y_detect: got %0d want %0d", name, oy, exp_y); end
    checks++;
    if (opos !== 20'(exp_pos)) begin errors++; $display("FAIL %s pos: got %0d want %0d", name, opos, exp_pos); end
  endtask

  task automatic run_frame(input string name);
    int lat;
    model_frame(lat);
    stream_frame();
    end_frame_and_check(name, lat);
  endtask

  task automatic test_reset();
    apply_reset();
    @(posedge clk); #1;
    checks++; if (bus.x_detect !== 10'd0) begin errors++; $display("FAIL reset x_detect: got %0d want 0", bus.x_detect); end
    checks++; if (bus.y_detect !== 9'd0) begin errors++; $display("FAIL reset y_detect: got %0d want 0", bus.y_detect); end
    checks++; if (bus.detect_pos_pixel !== 20'd0) begin errors++; $display("FAIL reset pos: got %0d want 0", bus.detect_pos_pixel); end
    checks++; if (bus.found !== 1'b0) begin errors++; $display("FAIL reset found: got %b want 0", bus.found); end
    checks++; if (bus.detect_valid !== 1'b0) begin errors++; $display("FAIL reset detect_valid: got %b want 0", bus.detect_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", bus.busy); end
  endtask

  // 10x10 block at cols 100..109, rows 50..59 -> (104, 54), pos 34664.
  task automatic test_block();
    fill(60, 8'd0);
    put_block(100, 109, 50, 59, 8'd255);
    run_frame("block");
  endtask

  // Only 10 lit pixels: no detection, coordinates hold.
  task automatic test_below_min();
    fill(1, 8'd0);
    for (int j = 0; j < 10; j++) img[j * 60 + $urandom_range(0, 59)] = 8'd255;
    run_frame("below_min");
  endtask

  // 199 everywhere is dark; the 200 block at cols/rows 0..9 -> (4, 4).
  task automatic test_threshold();
    fill(10, 8'd199);
    put_block(0, 9, 0, 9, 8'd200);
    run_frame("threshold");
  endtask

  // Exactly MIN_COUNT-1 and MIN_COUNT lit pixels.
  task automatic test_min_boundary();
    for (int n = MIN_COUNT - 1; n <= MIN_COUNT; n++) begin
      fill(1, 8'd0);
      for (int j = 0; j < n; j++) img[j * 40 + $urandom_range(0, 39)] = 8'($urandom_range(THRESH, 255));
      run_frame(n < MIN_COUNT ? "min_minus1" : "min_exact");
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      fill($urandom_range(1, 4), 8'd0);
      foreach (img[i])
        img[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(THRESH, 255))
                                             : 8'($urandom_range(0, THRESH - 1));
      run_frame("random_dense");
    end
    for (int f = 0; f < 2; f++) begin
      fill(1, 8'd0);
      for (int j = 0; j < $urandom_range(10, 22); j++) img[$urandom_range(0, H_RES - 1)] = 8'd255;
      run_frame("random_sparse");
    end
  endtask

  // A second frame end while dividing is dropped; the frame after that
  // must start from cleared accumulators.
  task automatic test_back_to_back();
    int          lat, pulses = 0, seen = -1;
    logic [9:0]  ox = 'x;
    logic [8:0]  oy = 'x;
    logic [19:0] opos = 'x;
    logic        ofound = 1'bx;
    fill(4, 8'd0);
    put_block(200, 209, 1, 3, 8'd255);
    model_frame(lat);
    stream_frame();
    @(negedge clk);
    bus.vsync = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      if (bus.detect_valid === 1'b1) begin
        pulses++;
        if (seen < 0) begin
          seen = k; ox = bus.x_detect; oy = bus.y_detect;
          opos = bus.detect_pos_pixel; ofound = bus.found;
        end
      end
      @(negedge clk);
      if (k == 3) bus.vsync = 1'b0;
      bus.pixel_valid = (k >= 5 && k <= 8);
      bus.pixel       = (k >= 5 && k <= 8) ? 8'd255 : 8'd0;
      if (k == 10) bus.vsync = 1'b1;
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL b2b pulses: got %0d want 1", pulses); end
    checks++;
    if (seen != lat) begin errors++; $display("FAIL b2b latency: got %0d want %0d", seen, lat); end
    checks++;
    if (ofound !== exp_found) begin errors++; $display("FAIL b2b found: got %b want %b", ofound, exp_found); end
    checks++;
    if ({ox, oy, opos} !== {10'(exp_x), 9'(exp_y), 20'(exp_pos)}) begin
      errors++;
      $display("FAIL b2b result: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", ox, oy, opos, exp_x, exp_y, exp_pos);
    end
    fill(6, 8'd0);
    put_block(300, 309, 2, 5, 8'd255);
    run_frame("b2b_next");
  endtask

  // Reset in the middle of a division: no pulse, outputs zero, and the
  // next complete frame is reported correctly.
  task automatic test_reset_mid_div();
    int pulses = 0;
    fill(3, 8'd0);
    put_block(20, 29, 0, 2, 8'd255);
    stream_frame();
    @(negedge clk);
    bus.vsync = 1'b1;
    @(posedge clk);
    repeat (15) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (bus.x_detect !== 10'd0) begin errors++; $display("FAIL middiv x_detect: got %0d want 0", bus.x_detect); end
    checks++; if (bus.y_detect !== 9'd0) begin errors++; $display("FAIL middiv y_detect: got %0d want 0", bus.y_detect); end
    checks++; if (bus.detect_pos_pixel !== 20'd0) begin errors++; $display("FAIL middiv pos: got %0d want 0", bus.detect_pos_pixel); end
    checks++; if (bus.found !== 1'b0) begin errors++; $display("FAIL middiv found: got %b want 0", bus.found); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL middiv busy: got %b want 0", bus.busy); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.detect_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL middiv stray pulses: got %0d want 0", pulses); end
    fill(5, 8'd0);
    put_block($urandom_range(0, 600), 0, 0, 0, 8'd0);
    begin
      int c0 = $urandom_range(0, 620);
      int r0 = $urandom_range(0, 2);
      put_block(c0, c0 + 9, r0, r0 + 2, 8'd255);
    end
    run_frame("middiv_next");
  endtask

`ifdef DETECT_SMOOTH_EN
  // Found frames centred at x=100 then x=200: 100, then (100+200)/2.
  task automatic test_smooth();
    apply_reset();
    fill(3, 8'd0);
    put_block(96, 105, 1, 2, 8'd255);
    run_frame("smooth_first");
    fill(3, 8'd0);
    put_block(196, 205, 1, 2, 8'd255);
    run_frame("smooth_second");
  endtask
`endif

  initial begin
    bus.vsync = 1'b1; bus.pixel_valid = 1'b0; bus.pixel = 8'd0;
    model_clear();
    test_reset();
    test_block();
    test_below_min();
    test_threshold();
    test_min_boundary();
    test_random();
    test_back_to_back();
    test_reset_mid_div();
`ifdef DETECT_SMOOTH_EN
    test_smooth();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
